// File: rtl/ipml_hsst_txlane_rst_fsm_v1_0_pkg.sv
// Shared HSST reset definitions: FSM state encodings, counter width and
// the reset-delay formulas used by the PLL, TX-lane and RX-lane sequencers.
package ipml_hsst_txlane_rst_fsm_v1_0_pkg;

   localparam int CNTR_WIDTH = 14;

   typedef enum logic [2:0] {
      TX_IDLE      = 3'd0,
      TX_LANE_PD   = 3'd1,
      TX_PMA_RST   = 3'd2,
      TX_PCS_RST   = 3'd3,
      TX_DONE      = 3'd4,
      TX_WAIT_LOCK = 3'd5
   } tx_state_e;

   // Simulation speed-up shortens every reset delay by a factor of ten.
`ifdef IPML_HSST_SPEEDUP_SIM
   localparam int SIM_DIV = 10;
`else
   localparam int SIM_DIV = 1;
`endif

   function automatic logic [CNTR_WIDTH-1:0] dly_value(input int mult, input int freq);
      int v;
      v = (2 * mult * freq) / SIM_DIV;
      return v[CNTR_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/ipml_hsst_txlane_rst_fsm_v1_0_sync.sv
// Two-flop synchronizer for a single asynchronous level (e.g. PLL lock).
// Output follows the input with two clock cycles of latency.
module ipml_hsst_rst_sync_v1_0 (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= 2'b00;
      else        r_sync <= {r_sync[0], i_d};
   end

   assign o_q = r_sync[1];

endmodule

// File: rtl/ipml_hsst_txlane_rst_fsm_v1_0.sv
// TX-lane reset sequencer: after PLL done and lock, releases lane power-down,
// PMA reset and PCS TX reset in turn; re-runs PMA/PCS release on lock loss.
module ipml_hsst_txlane_rst_fsm_v1_0
   import ipml_hsst_txlane_rst_fsm_v1_0_pkg::*;
#(
   parameter int FREE_CLOCK_FREQ  = 100,
   parameter int LOCK_LOSS_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_pll_done,
   input  logic       pll_lock,
   output logic       P_TX_LANE_PD,
   output logic       P_TX_PMA_RST,
   output logic       P_PCS_TX_RST,
   output logic       o_txlane_done,
   output logic       o_lock_lost,
   output logic [7:0] o_lock_lost_cnt,
   output logic [2:0] o_dbg_state
);

   localparam logic [CNTR_WIDTH-1:0] TX_PD_CNTR_VALUE  = dly_value(1, FREE_CLOCK_FREQ);
   localparam logic [CNTR_WIDTH-1:0] TX_PMA_CNTR_VALUE = dly_value(2, FREE_CLOCK_FREQ);
   localparam logic [CNTR_WIDTH-1:0] TX_PCS_CNTR_VALUE = dly_value(1, FREE_CLOCK_FREQ);
   localparam logic [7:0]            LOSS_N            = 8'(LOCK_LOSS_CYCLES);
   localparam logic [7:0]            LOSS_LAST         = 8'(LOCK_LOSS_CYCLES - 1);

   tx_state_e             r_state, w_state_nxt;
   logic [CNTR_WIDTH-1:0] r_cntr, w_cntr_nxt, w_term_val;
   logic                  r_lane_pd, w_lane_pd_nxt;
   logic                  r_pma_rst, w_pma_rst_nxt;
   logic                  r_pcs_rst, w_pcs_rst_nxt;
   logic                  r_done, w_done_nxt;
   logic                  r_lost, w_lost_nxt;
   logic [7:0]            r_lost_cnt, w_lost_cnt_nxt, w_lost_cnt_inc;
   logic [7:0]            r_filt;
   logic                  w_lock_s, w_lock_lost, w_rst_outs;

   ipml_hsst_rst_sync_v1_0 u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (pll_lock),
      .o_q   (w_lock_s)
   );

   // Filter counts synced-low cycles and parks at LOSS_N until lock returns,
   // so one outage declares exactly one loss event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             r_filt <= 8'd0;
      else if (w_lock_s)      r_filt <= 8'd0;
      else if (r_filt != LOSS_N) r_filt <= r_filt + 8'd1;
   end

   assign w_lock_lost    = !w_lock_s && (r_filt == LOSS_LAST);
   assign w_lost_cnt_inc = (r_lost_cnt == 8'hFF) ? r_lost_cnt : r_lost_cnt + 8'd1;
   assign w_term_val     = (r_state == TX_PMA_RST) ? TX_PMA_CNTR_VALUE :
                           (r_state == TX_PCS_RST) ? TX_PCS_CNTR_VALUE : TX_PD_CNTR_VALUE;

   always_comb begin
      w_state_nxt    = r_state;
      w_cntr_nxt     = r_cntr;
      w_lane_pd_nxt  = r_lane_pd;
      w_pma_rst_nxt  = r_pma_rst;
      w_pcs_rst_nxt  = r_pcs_rst;
      w_done_nxt     = r_done;
      w_lost_nxt     = 1'b0;
      w_lost_cnt_nxt = r_lost_cnt;
      w_rst_outs     = 1'b0;
      case (r_state)
         TX_IDLE: begin
            w_rst_outs = 1'b1;
            if (i_pll_done && w_lock_s) w_state_nxt = TX_LANE_PD;
         end
         TX_LANE_PD, TX_PMA_RST, TX_PCS_RST, TX_DONE: begin
            if (!i_pll_done) begin
               w_state_nxt = TX_IDLE;
               w_rst_outs  = 1'b1;
            end else if (w_lock_lost) begin
               w_lost_nxt     = 1'b1;
               w_lost_cnt_nxt = w_lost_cnt_inc;
               w_cntr_nxt     = '0;
               if (r_state == TX_LANE_PD) begin
                  w_state_nxt = TX_IDLE;
                  w_rst_outs  = 1'b1;
               end else begin
                  w_state_nxt   = TX_WAIT_LOCK;
                  w_pma_rst_nxt = 1'b1;
                  w_pcs_rst_nxt = 1'b1;
                  w_done_nxt    = 1'b0;
               end
            end else if (r_state == TX_DONE) begin
               w_done_nxt = 1'b1;
            end else if (r_cntr != w_term_val) begin
               w_cntr_nxt = r_cntr + 1'b1;
            end else begin
               w_cntr_nxt = '0;
               if (r_state == TX_LANE_PD) begin
                  w_lane_pd_nxt = 1'b0;
                  w_state_nxt   = TX_PMA_RST;
               end else if (r_state == TX_PMA_RST) begin
                  w_pma_rst_nxt = 1'b0;
                  w_state_nxt   = TX_PCS_RST;
               end else begin
                  w_pcs_rst_nxt = 1'b0;
                  w_state_nxt   = TX_DONE;
               end
            end
         end
         TX_WAIT_LOCK: begin
            if (!i_pll_done) begin
               w_state_nxt = TX_IDLE;
               w_rst_outs  = 1'b1;
            end else begin
               w_pma_rst_nxt = 1'b1;
               w_pcs_rst_nxt = 1'b1;
               w_done_nxt    = 1'b0;
               w_cntr_nxt    = '0;
               if (w_lock_s && (r_filt == 8'd0)) w_state_nxt = TX_PMA_RST;
            end
         end
         default: begin
            w_state_nxt = TX_IDLE;
            w_rst_outs  = 1'b1;
         end
      endcase
      // Loss counter is deliberately kept across upstream restarts.
      if (w_rst_outs) begin
         w_cntr_nxt    = '0;
         w_lane_pd_nxt = 1'b1;
         w_pma_rst_nxt = 1'b1;
         w_pcs_rst_nxt = 1'b1;
         w_done_nxt    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= TX_IDLE;
         r_cntr     <= '0;
         r_lane_pd  <= 1'b1;
         r_pma_rst  <= 1'b1;
         r_pcs_rst  <= 1'b1;
         r_done     <= 1'b0;
         r_lost     <= 1'b0;
         r_lost_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_cntr     <= w_cntr_nxt;
         r_lane_pd  <= w_lane_pd_nxt;
         r_pma_rst  <= w_pma_rst_nxt;
         r_pcs_rst  <= w_pcs_rst_nxt;
         r_done     <= w_done_nxt;
         r_lost     <= w_lost_nxt;
         r_lost_cnt <= w_lost_cnt_nxt;
      end
   end

   assign P_TX_LANE_PD    = r_lane_pd;
   assign P_TX_PMA_RST    = r_pma_rst;
   assign P_PCS_TX_RST    = r_pcs_rst;
   assign o_txlane_done   = r_done;
   assign o_lock_lost     = r_lost;
   assign o_lock_lost_cnt = r_lost_cnt;
   assign o_dbg_state     = r_state;

endmodule
